// File: rtl/apb_master.sv
// APB requester: turns a valid/ready command stream into APB SETUP/ACCESS transfers
// and returns exactly one response per accepted command.
//
// state  | meaning
// IDLE   | no transfer in flight, cmd_ready high
// SETUP  | PSEL high, PENABLE low, one cycle
// ACCESS | PSEL/PENABLE high, waiting for PREADY or the wait-cycle limit
module apb_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_timeout,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;

    // Counter only has to reach TIMEOUT-1; the abort fires on that value.
    localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST_C = CNT_W'(TO_LAST);

    logic [1:0]       state;
    logic [CNT_W-1:0] wait_cnt;

    assign cmd_ready = (state == S_IDLE);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        PADDR  <= cmd_addr;
                        PWRITE <= cmd_write;
                        PWDATA <= cmd_wdata;
                        PSEL   <= 1'b1;
                        state  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    PENABLE  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (PREADY) begin
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= PWRITE ? '0 : PRDATA;
                        state     <= S_IDLE;
                    end else if ((TIMEOUT != 0) && (wait_cnt == TO_LAST_C)) begin
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                        state       <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: one instance with the default wait limit,
// a second with the limit disabled.
module tb_apb_master;

    logic        PCLK;
    logic        PRESETn;
    logic        cmd_valid, cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [31:0] PRDATA;
    logic        PREADY;

    logic        cmd_ready, rsp_valid, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        PSEL, PENABLE, PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;

    logic        cmd_valid1, PREADY1;
    logic        cmd_ready1, rsp_valid1, rsp_timeout1;
    logic [31:0] rsp_rdata1;
    logic        PSEL1, PENABLE1, PWRITE1;
    logic [7:0]  PADDR1;
    logic [31:0] PWDATA1;

    int errors = 0;
    int checks = 0;

    apb_master #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    apb_master #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT(0)) dut_nto (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .rsp_timeout(rsp_timeout1),
        .PSEL(PSEL1), .PENABLE(PENABLE1), .PWRITE(PWRITE1), .PADDR(PADDR1),
        .PWDATA(PWDATA1), .PRDATA(PRDATA), .PREADY(PREADY1)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic test_reset;
        @(negedge PCLK);
        checks++;
        if ({PSEL, PENABLE, PWRITE, rsp_valid, rsp_timeout, cmd_ready} !== 6'b000001) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 000001", {PSEL, PENABLE, PWRITE, rsp_valid, rsp_timeout, cmd_ready});
        end
        checks++;
        if (PADDR !== 8'h00 || PWDATA !== 32'h0 || rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h want all 0", PADDR, PWDATA, rsp_rdata);
        end
        PRESETn = 1'b1;
        @(negedge PCLK);
    endtask

    task automatic test_write_zero_wait;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h10; cmd_wdata = 32'hDEADBEEF;
        PREADY = 1'b1;
        @(negedge PCLK);
        cmd_valid = 1'b0; cmd_addr = 8'hFF; cmd_wdata = 32'h0;
        checks++;
        if ({PSEL, PENABLE, cmd_ready} !== 3'b100) begin
            errors++;
            $display("FAIL wr_setup_ctrl: got psel/pen/rdy=%b want 100", {PSEL, PENABLE, cmd_ready});
        end
        checks++;
        if (PADDR !== 8'h10 || PWRITE !== 1'b1 || PWDATA !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL wr_setup_bus: got %h/%b/%h want 10/1/deadbeef", PADDR, PWRITE, PWDATA);
        end
        @(negedge PCLK);
        checks++;
        if ({PSEL, PENABLE} !== 2'b11 || PADDR !== 8'h10 || PWRITE !== 1'b1 || PWDATA !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL wr_access: got sel/en=%b %h/%b/%h want 11 10/1/deadbeef", {PSEL, PENABLE}, PADDR, PWRITE, PWDATA);
        end
        @(negedge PCLK);
        checks++;
        if ({rsp_valid, rsp_timeout, PSEL, PENABLE, cmd_ready} !== 5'b10001 || rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL wr_resp: got v/to/sel/en/rdy=%b rdata=%h want 10001 0", {rsp_valid, rsp_timeout, PSEL, PENABLE, cmd_ready}, rsp_rdata);
        end
        @(negedge PCLK);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL wr_resp_pulse: got rsp_valid=%b want 0", rsp_valid);
        end
    endtask

    task automatic test_read_wait;
        int acc;
        int pulses;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h10; PREADY = 1'b0; PRDATA = 32'h0;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        checks++;
        if ({PSEL, PENABLE, PWRITE} !== 3'b100 || PADDR !== 8'h10) begin
            errors++;
            $display("FAIL rd_setup: got sel/en/wr=%b addr=%h want 100 10", {PSEL, PENABLE, PWRITE}, PADDR);
        end
        acc = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            if (PENABLE === 1'b1) acc++;
            if (i == 2) begin
                PREADY = 1'b1; PRDATA = 32'hDEADBEEF;
            end
        end
        checks++;
        if (acc !== 3) begin
            errors++;
            $display("FAIL rd_access_len: got %0d want 3", acc);
        end
        @(negedge PCLK);
        PRDATA = 32'h0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'hDEADBEEF || PSEL !== 1'b0) begin
            errors++;
            $display("FAIL rd_resp: got v=%b to=%b rdata=%h sel=%b want 1 0 deadbeef 0", rsp_valid, rsp_timeout, rsp_rdata, PSEL);
        end
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            if (rsp_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL rd_resp_once: got %0d extra pulses want 0", pulses);
        end
    endtask

    task automatic test_timeout;
        int acc;
        bit done;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h20; PREADY = 1'b0; PRDATA = 32'h12345678;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        acc = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge PCLK);
            if (PENABLE === 1'b1) acc++;
            else done = 1'b1;
        end
        checks++;
        if (!done || acc !== 16) begin
            errors++;
            $display("FAIL to_access_len: got %0d cycles (ended=%0d) want 16", acc, done);
        end
        checks++;
        if ({rsp_valid, rsp_timeout, PSEL, PENABLE, cmd_ready} !== 5'b11001 || rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL to_resp: got v/to/sel/en/rdy=%b rdata=%h want 11001 0", {rsp_valid, rsp_timeout, PSEL, PENABLE, cmd_ready}, rsp_rdata);
        end
        @(negedge PCLK);
        checks++;
        if (rsp_valid !== 1'b0 || rsp_timeout !== 1'b0) begin
            errors++;
            $display("FAIL to_resp_pulse: got v=%b to=%b want 0 0", rsp_valid, rsp_timeout);
        end
    endtask

    task automatic test_back_to_back;
        logic [8:0] sel_e, en_e, rsp_e, rdy_e;
        logic [7:0] addr_e;
        sel_e = 9'b011011011;
        en_e  = 9'b010010010;
        rsp_e = 9'b100100100;
        rdy_e = 9'b100100100;
        PREADY = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h01; cmd_wdata = 32'h11;
        for (int i = 1; i <= 9; i++) begin
            @(negedge PCLK);
            addr_e = 8'((i + 2) / 3);
            checks++;
            if ({PSEL, PENABLE, rsp_valid, cmd_ready} !== {sel_e[i-1], en_e[i-1], rsp_e[i-1], rdy_e[i-1]}) begin
                errors++;
                $display("FAIL b2b_ctrl[%0d]: got sel/en/v/rdy=%b want %b", i, {PSEL, PENABLE, rsp_valid, cmd_ready},
                         {sel_e[i-1], en_e[i-1], rsp_e[i-1], rdy_e[i-1]});
            end
            checks++;
            if (PADDR !== addr_e || PWDATA !== {24'h0, addr_e[3:0], addr_e[3:0]} || PWRITE !== 1'b1) begin
                errors++;
                $display("FAIL b2b_bus[%0d]: got %h/%h/%b want %h/%h/1", i, PADDR, PWDATA, PWRITE, addr_e,
                         {24'h0, addr_e[3:0], addr_e[3:0]});
            end
            if (i == 1) begin cmd_addr = 8'h02; cmd_wdata = 32'h22; end
            if (i == 4) begin cmd_addr = 8'h03; cmd_wdata = 32'h33; end
            if (i == 7) cmd_valid = 1'b0;
        end
        @(negedge PCLK);
        checks++;
        if (rsp_valid !== 1'b0 || PSEL !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_end: got v=%b sel=%b rdy=%b want 0 0 1", rsp_valid, PSEL, cmd_ready);
        end
    endtask

    task automatic test_reset_mid;
        int pulses;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h30; PREADY = 1'b0;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK);
        checks++;
        if ({PSEL, PENABLE} !== 2'b11) begin
            errors++;
            $display("FAIL rst_mid_pre: got sel/en=%b want 11", {PSEL, PENABLE});
        end
        PRESETn = 1'b0;
        #1;
        checks++;
        if ({PSEL, PENABLE, rsp_valid, cmd_ready} !== 4'b0001 || PADDR !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_async: got sel/en/v/rdy=%b addr=%h want 0001 00", {PSEL, PENABLE, rsp_valid, cmd_ready}, PADDR);
        end
        @(negedge PCLK);
        PRESETn = 1'b1;
        PREADY = 1'b1;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge PCLK);
            if (rsp_valid === 1'b1 || PSEL === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL rst_mid_quiet: got %0d active cycles want 0", pulses);
        end
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h44; cmd_wdata = 32'hA5A5A5A5;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'h0 || PADDR !== 8'h44) begin
            errors++;
            $display("FAIL rst_mid_next: got v=%b to=%b rdata=%h addr=%h want 1 0 0 44", rsp_valid, rsp_timeout, rsp_rdata, PADDR);
        end
    endtask

    task automatic test_no_timeout;
        int bad;
        cmd_valid1 = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h55; PREADY1 = 1'b0; PRDATA = 32'hCAFEF00D;
        @(negedge PCLK);
        cmd_valid1 = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge PCLK);
            if (PENABLE1 !== 1'b1 || rsp_valid1 !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL nto_hold: got %0d bad cycles want 0", bad);
        end
        @(negedge PCLK);
        PREADY1 = 1'b1;
        @(negedge PCLK);
        checks++;
        if (rsp_valid1 !== 1'b1 || rsp_timeout1 !== 1'b0 || rsp_rdata1 !== 32'hCAFEF00D || PSEL1 !== 1'b0) begin
            errors++;
            $display("FAIL nto_resp: got v=%b to=%b rdata=%h sel=%b want 1 0 cafef00d 0", rsp_valid1, rsp_timeout1, rsp_rdata1, PSEL1);
        end
        PREADY1 = 1'b0;
    endtask

    initial begin
        PRESETn = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h0; cmd_wdata = 32'h0;
        PRDATA = 32'h0; PREADY = 1'b0;
        cmd_valid1 = 1'b0; PREADY1 = 1'b0;
        test_reset;
        test_write_zero_wait;
        test_read_wait;
        test_timeout;
        test_back_to_back;
        test_reset_mid;
        test_no_timeout;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB requester (initiator) that converts a simple valid/ready command stream into APB SETUP/ACCESS transfers toward slave blocks on the same bus.
- Returns one response per command: read data or write completion, plus a timeout flag.
- Sits between a CPU/DMA-side command source and the APB slave fabric (8-bit address, 32-bit data).
- One outstanding transfer at a time, no pipelining.

Parameters:
- ADDR_WIDTH, 8, width of PADDR / cmd_addr
- DATA_WIDTH, 32, width of PWDATA / PRDATA / cmd_wdata / rsp_rdata
- TIMEOUT, 16, max ACCESS cycles with PREADY low before abort; 0 disables timeout

Ports:
- PCLK  in  1  bus clock; all logic on rising edge
- PRESETn  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  master idle, command accepted when valid&ready
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_WIDTH  target address
- cmd_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  one-cycle response pulse, no backpressure
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes and timeouts)
- rsp_timeout  out  1  qualifies rsp_valid: transfer aborted
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PADDR  out  ADDR_WIDTH  APB address
- PWDATA  out  DATA_WIDTH  APB write data
- PRDATA  in  DATA_WIDTH  APB read data
- PREADY  in  1  APB ready / wait-state control

Behaviour:
- Reset (async on PRESETn low): state=IDLE; PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_timeout all 0; wait counter 0.
- All outputs except cmd_ready are registered. cmd_ready = (state==IDLE), combinational from state only.
- IDLE: PSEL=0, PENABLE=0. On cmd_valid&&cmd_ready, capture cmd_addr/cmd_write/cmd_wdata into PADDR/PWRITE/PWDATA; go to SETUP. cmd_valid in other states is ignored (not consumed).
- SETUP (one cycle): PSEL=1, PENABLE=0; always go to ACCESS; counter cleared.
- ACCESS: PSEL=1, PENABLE=1. PADDR/PWRITE/PWDATA stable from SETUP through end of ACCESS.
  - PREADY=1 at rising edge: complete. Reads register PRDATA into rsp_rdata; writes set rsp_rdata=0. Pulse rsp_valid=1 with rsp_timeout=0 for the following cycle. Drop PSEL/PENABLE; go to IDLE.
  - PREADY=0: increment counter. If TIMEOUT!=0 and this is the TIMEOUT-th ACCESS cycle, abort: drop PSEL/PENABLE, rsp_valid=1, rsp_timeout=1, rsp_rdata=0; go to IDLE.
- Zero-wait transfer: accept at edge N, SETUP cycle N+1, ACCESS cycle N+2, rsp_valid and cmd_ready high in cycle N+3. Minimum 3 cycles per transfer.
- Back-to-back: held cmd_valid is accepted in the same cycle rsp_valid pulses. The next SETUP follows immediately, with one PSEL-low cycle between transfers.
- PADDR/PWRITE/PWDATA retain their last values in IDLE.
- rsp_valid is high exactly one cycle per accepted command.
- Counter width: enough bits for TIMEOUT; saturation is not required, since the abort fires first.
- Reset mid-transfer: outputs return to reset values immediately. No response is issued for the in-flight command.

Test Plan:
- Write addr 0x10, data 0xDEADBEEF, PREADY tied 1 -> PSEL rises cycle N+1, PENABLE N+2; PADDR=0x10, PWRITE=1, PWDATA=0xDEADBEEF stable both cycles; rsp_valid=1, rsp_timeout=0, rsp_rdata=0 at N+3.
- Read addr 0x10, PREADY low 2 ACCESS cycles, PRDATA=0xDEADBEEF on ready -> ACCESS lasts 3 cycles; rsp_rdata=0xDEADBEEF, rsp_valid one cycle.
- Read with PREADY never asserted, TIMEOUT=16 -> PSEL/PENABLE drop after exactly 16 ACCESS cycles; rsp_valid=1, rsp_timeout=1, rsp_rdata=0; cmd_ready returns 1.
- cmd_valid held, 3 writes (0x01, 0x02, 0x03) -> three SETUP/ACCESS pairs, each separated by one PSEL=0 cycle; three rsp_valid pulses; cmd_ready low while busy.
- PRESETn asserted during ACCESS with PREADY=0 -> PSEL, PENABLE, rsp_valid all 0 immediately, no response after release; next command completes normally.
- TIMEOUT=0, PREADY low 100 cycles then 1 -> no abort; normal response, rsp_timeout=0.
